// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: owns the fetch PC, the decode instruction register
// and a two-deep history of older instructions (EX, MEM). It detects
// load-use hazards against the instruction in EX and inserts one bubble
// per hazard. Redirects from downstream flush the decode slot.
module if_id_stage #(
  parameter int               ISIZE = 16,
  parameter int               RSIZE = 4,
  parameter logic [ISIZE-1:0] NOP   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             redirect_en,
  input  logic [15:0]      redirect_pc,
  output logic [15:0]      imem_addr,
  input  logic [ISIZE-1:0] imem_rdata,
  input  logic             imem_ready,
  output logic [ISIZE-1:0] Instr,
  output logic [ISIZE-1:0] LastInstr,
  output logic [ISIZE-1:0] Last2Instr,
  output logic [3:0]       OpCode,
  output logic [2:0]       Cond,
  output logic [RSIZE-1:0] AddrRd,
  output logic [RSIZE-1:0] AddrRs,
  output logic [RSIZE-1:0] AddrRt,
  output logic [15:0]      PCPlus1,
  output logic             load_stall
);

  localparam logic [3:0] OP_LW = 4'h8;

  logic [15:0]      pc_q, pc_d;
  logic [15:0]      pcplus1_q, pcplus1_d;
  logic [ISIZE-1:0] instr_q, instr_d;
  logic [ISIZE-1:0] last_q, last_d;
  logic [ISIZE-1:0] last2_q, last2_d;

  logic [RSIZE-1:0] rd_last;
  logic             reads_rd_last;

  // Decode fields are plain slices of the decode register.
  assign OpCode = instr_q[15:12];
  assign Cond   = instr_q[11:9];
  assign AddrRd = instr_q[8 +: RSIZE];
  assign AddrRs = instr_q[4 +: RSIZE];
  assign AddrRt = instr_q[0 +: RSIZE];

  assign imem_addr  = pc_q;
  assign Instr      = instr_q;
  assign LastInstr  = last_q;
  assign Last2Instr = last2_q;
  assign PCPlus1    = pcplus1_q;

  assign rd_last = last_q[8 +: RSIZE];

  // Does the decode instruction source the register the EX-stage load writes?
  always_comb begin
    reads_rd_last = 1'b0;
    if ((OpCode <= 4'h9) && (AddrRs == rd_last)) reads_rd_last = 1'b1;
    if ((OpCode <= 4'h4) && (AddrRt == rd_last)) reads_rd_last = 1'b1;
    if ((OpCode inside {4'h9, 4'hA, 4'hB, 4'hE, 4'hF}) && (AddrRd == rd_last))
      reads_rd_last = 1'b1;
  end

  // Load-use bubble; hold, redirect and reset all take priority over it.
  assign load_stall = !rst && !hold && !redirect_en &&
                      (last_q[15:12] == OP_LW) && (rd_last != '0) &&
                      reads_rd_last;

  // Next-state selection in priority order: hold > redirect > stall >
  // not-ready > advance. Reset is applied in the register process.
  // PCPlus1 only tracks real fetches, so it keeps its value whenever a NOP
  // (rather than a fetched word) enters decode.
  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path through
    // this block can leave one unassigned and infer a latch.
    pc_d      = pc_q;
    pcplus1_d = pcplus1_q;
    instr_d   = instr_q;
    last_d    = last_q;
    last2_d   = last2_q;
    if (hold) begin
      // everything frozen
    end else if (redirect_en) begin
      pc_d    = redirect_pc;
      instr_d = NOP;
      last_d  = instr_q;
      last2_d = last_q;
    end else if (load_stall) begin
      last_d  = NOP;
      last2_d = last_q;
    end else if (!imem_ready) begin
      instr_d = NOP;
      last_d  = instr_q;
      last2_d = last_q;
    end else begin
      pc_d      = pc_q + 16'd1;
      pcplus1_d = pc_q + 16'd1;
      instr_d   = imem_rdata;
      last_d    = instr_q;
      last2_d   = last_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values of its peers, independent of statement order.
    if (rst) begin
      pc_q      <= '0;
      pcplus1_q <= '0;
      instr_q   <= NOP;
      last_q    <= NOP;
      last2_q   <= NOP;
    end else begin
      pc_q      <= pc_d;
      pcplus1_q <= pcplus1_d;
      instr_q   <= instr_d;
      last_q    <= last_d;
      last2_q   <= last2_d;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed, table-driven bench for if_id_stage. Each record gives the inputs
// for one cycle, the expected load_stall during that cycle, and the expected
// register contents after the following rising edge.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst, hold, redirect_en, imem_ready;
  logic [15:0] redirect_pc, imem_addr, imem_rdata;
  logic [15:0] Instr, LastInstr, Last2Instr, PCPlus1;
  logic [3:0]  OpCode;
  logic [2:0]  Cond;
  logic [3:0]  AddrRd, AddrRs, AddrRt;
  logic        load_stall;

  logic [15:0] mem [0:255];

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        rst;
    logic        hold;
    logic        redir;
    logic [15:0] rpc;
    logic        rdy;
    logic        ls;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] last;
    logic [15:0] last2;
    logic [15:0] p1;
  } vec_t;

  if_id_stage dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .Instr      (Instr),
    .LastInstr  (LastInstr),
    .Last2Instr (Last2Instr),
    .OpCode     (OpCode),
    .Cond       (Cond),
    .AddrRd     (AddrRd),
    .AddrRs     (AddrRs),
    .AddrRt     (AddrRt),
    .PCPlus1    (PCPlus1),
    .load_stall (load_stall)
  );

  always #5 clk = ~clk;

  // Instruction memory model: combinational read of the low address byte.
  assign imem_rdata = mem[imem_addr[7:0]];

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the stall flag, clock, check state.
  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    rst         = v.rst;
    hold        = v.hold;
    redirect_en = v.redir;
    redirect_pc = v.rpc;
    imem_ready  = v.rdy;
    #1;
    check({tag, ".load_stall"}, {15'd0, load_stall}, {15'd0, v.ls});
    @(posedge clk);
    #1;
    n_vec++;
    check({tag, ".pc"},         imem_addr,  v.pc);
    check({tag, ".instr"},      Instr,      v.instr);
    check({tag, ".last"},       LastInstr,  v.last);
    check({tag, ".last2"},      Last2Instr, v.last2);
    check({tag, ".pcplus1"},    PCPlus1,    v.p1);
    check({tag, ".opcode"},     {12'd0, OpCode}, {12'd0, v.instr[15:12]});
    check({tag, ".cond"},       {13'd0, Cond},   {13'd0, v.instr[11:9]});
    check({tag, ".rd"},         {12'd0, AddrRd}, {12'd0, v.instr[11:8]});
    check({tag, ".rs"},         {12'd0, AddrRs}, {12'd0, v.instr[7:4]});
    check({tag, ".rt"},         {12'd0, AddrRt}, {12'd0, v.instr[3:0]});
  endtask

  // rst/hold/redir/rpc/rdy | ls | pc instr last last2 pcplus1
  vec_t tbl [22];
  vec_t rst_v;

  initial begin
    rst = 1'b1; hold = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    imem_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'h0123; mem[1] = 16'h1456; mem[2] = 16'h2789;
    mem[3] = 16'h8310; mem[4] = 16'h0432; mem[5] = 16'h8010;
    mem[6] = 16'h0400; mem[7] = 16'h1111;

    rst_v = '{1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};

    // Reset with hold and redirect asserted: reset must win.
    tbl[0]  = '{1, 1, 1, 16'h0055, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    // Three plain fetches.
    tbl[1]  = '{0, 0, 0, 16'h0000, 1, 0, 16'h0001, 16'h0123, 16'h0000, 16'h0000, 16'h0001};
    tbl[2]  = '{0, 0, 0, 16'h0000, 1, 0, 16'h0002, 16'h1456, 16'h0123, 16'h0000, 16'h0002};
    tbl[3]  = '{0, 0, 0, 16'h0000, 1, 0, 16'h0003, 16'h2789, 16'h1456, 16'h0123, 16'h0003};
    // LW R3 then ADD R4,R3,R2: one bubble.
    tbl[4]  = '{0, 0, 0, 16'h0000, 1, 0, 16'h0004, 16'h8310, 16'h2789, 16'h1456, 16'h0004};
    tbl[5]  = '{0, 0, 0, 16'h0000, 1, 0, 16'h0005, 16'h0432, 16'h8310, 16'h2789, 16'h0005};
    tbl[6]  = '{0, 0, 0, 16'h0000, 1, 1, 16'h0005, 16'h0432, 16'h0000, 16'h8310, 16'h0005};
    // LW R0 then reader of R0: no bubble.
    tbl[7]  = '{0, 0, 0, 16'h0000, 1, 0, 16'h0006, 16'h8010, 16'h0432, 16'h0000, 16'h0006};
    tbl[8]  = '{0, 0, 0, 16'h0000, 1, 0, 16'h0007, 16'h0400, 16'h8010, 16'h0432, 16'h0007};
    tbl[9]  = '{0, 0, 0, 16'h0000, 1, 0, 16'h0008, 16'h1111, 16'h0400, 16'h8010, 16'h0008};
    // Redirect to 0x40 flushes decode, fetch resumes there.
    tbl[10] = '{0, 0, 1, 16'h0040, 1, 0, 16'h0040, 16'h0000, 16'h1111, 16'h0400, 16'h0008};
    tbl[11] = '{0, 0, 0, 16'h0000, 1, 0, 16'h0041, 16'h1040, 16'h0000, 16'h1111, 16'h0041};
    // Hold three cycles (with a redirect attempt inside) then resume.
    tbl[12] = '{0, 1, 0, 16'h0000, 1, 0, 16'h0041, 16'h1040, 16'h0000, 16'h1111, 16'h0041};
    tbl[13] = '{0, 1, 1, 16'h0080, 1, 0, 16'h0041, 16'h1040, 16'h0000, 16'h1111, 16'h0041};
    tbl[14] = '{0, 1, 0, 16'h0000, 0, 0, 16'h0041, 16'h1040, 16'h0000, 16'h1111, 16'h0041};
    tbl[15] = '{0, 0, 0, 16'h0000, 1, 0, 16'h0042, 16'h1041, 16'h1040, 16'h0000, 16'h0042};
    // Memory not ready for two cycles: two NOPs, PC parked.
    tbl[16] = '{0, 0, 0, 16'h0000, 0, 0, 16'h0042, 16'h0000, 16'h1041, 16'h1040, 16'h0042};
    tbl[17] = '{0, 0, 0, 16'h0000, 0, 0, 16'h0042, 16'h0000, 16'h0000, 16'h1041, 16'h0042};
    tbl[18] = '{0, 0, 0, 16'h0000, 1, 0, 16'h0043, 16'h1042, 16'h0000, 16'h0000, 16'h0043};
    // Redirect while not ready to 0xFFFF, then PC wraps to 0.
    tbl[19] = '{0, 0, 1, 16'hFFFF, 0, 0, 16'hFFFF, 16'h0000, 16'h1042, 16'h0000, 16'h0043};
    tbl[20] = '{0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h10FF, 16'h0000, 16'h1042, 16'h0000};
    tbl[21] = '{0, 0, 0, 16'h0000, 1, 0, 16'h0001, 16'h0123, 16'h10FF, 16'h0000, 16'h0001};

    for (int i = 0; i < 22; i++) apply($sformatf("tbl%0d", i), tbl[i]);

    // Redirect arriving in a load-use cycle: redirect wins, no bubble.
    apply("rd_stall.rst", rst_v);
    apply("rd_stall.jmp", '{0, 0, 1, 16'h0003, 1, 0, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    apply("rd_stall.lw",  '{0, 0, 0, 16'h0000, 1, 0, 16'h0004, 16'h8310, 16'h0000, 16'h0000, 16'h0004});
    apply("rd_stall.add", '{0, 0, 0, 16'h0000, 1, 0, 16'h0005, 16'h0432, 16'h8310, 16'h0000, 16'h0005});
    apply("rd_stall.win", '{0, 0, 1, 16'h0010, 1, 0, 16'h0010, 16'h0000, 16'h0432, 16'h8310, 16'h0005});
    apply("rd_stall.go",  '{0, 0, 0, 16'h0000, 1, 0, 16'h0011, 16'h1010, 16'h0000, 16'h0432, 16'h0011});

    // Reset pulsed during a load-use cycle, then first fetch from 0.
    apply("rst_stall.rst", rst_v);
    apply("rst_stall.jmp", '{0, 0, 1, 16'h0003, 1, 0, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    apply("rst_stall.lw",  '{0, 0, 0, 16'h0000, 1, 0, 16'h0004, 16'h8310, 16'h0000, 16'h0000, 16'h0004});
    apply("rst_stall.add", '{0, 0, 0, 16'h0000, 1, 0, 16'h0005, 16'h0432, 16'h8310, 16'h0000, 16'h0005});
    apply("rst_stall.hit", rst_v);
    apply("rst_stall.f0",  '{0, 0, 0, 16'h0000, 1, 0, 16'h0001, 16'h0123, 16'h0000, 16'h0000, 16'h0001});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
